// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_arbiter_pkg                                            |
// | Brief   : Shared widths and requester ids for the CDB arbiter.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH_BIT = 5;
    localparam int CDB_NUM_REQ   = 3;
    localparam int CDB_SRC_BIT   = 2;

    typedef enum logic [CDB_SRC_BIT-1:0] {
        CDB_SRC_ALU = 2'd0,
        CDB_SRC_LSB = 2'd1,
        CDB_SRC_MUL = 2'd2
    } cdb_src_e;

    // Round-robin successor, wrapping from the last requester back to 0.
    function automatic logic [CDB_SRC_BIT-1:0] cdb_next_src(
        input logic [CDB_SRC_BIT-1:0] src,
        input int                     num_req
    );
        return (int'(src) == num_req - 1) ? '0 : src + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_queue                                                  |
// | Brief   : Small per-requester result FIFO with synchronous flush.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cdb_queue #(
    parameter int DEPTH_BIT = 1,
    parameter int DATA_W    = 37
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);
    import cdb_arbiter_pkg::*;

    localparam int c_DEPTH = 1 << DEPTH_BIT;

    logic [DATA_W-1:0]    r_mem [c_DEPTH];
    logic [DEPTH_BIT-1:0] r_wr_ptr;
    logic [DEPTH_BIT-1:0] r_rd_ptr;
    logic [DEPTH_BIT:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (DEPTH_BIT+1)'(c_DEPTH));
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_in) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_arbiter                                                |
// | Brief   : Round-robin arbiter driving the registered common data bus.|
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = CDB_NUM_REQ,
    parameter int DEPTH_BIT = 1,
    parameter int ROB_W     = ROB_WIDTH_BIT
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ROB_W-1:0] req_rob_id,
    input  logic [NUM_REQ*32-1:0]    req_value,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     cdb_valid,
    output logic [ROB_W-1:0]         cdb_rob_id,
    output logic [31:0]              cdb_value,
    output logic [CDB_SRC_BIT-1:0]   cdb_src,
    output logic [15:0]              stall_count
);

    localparam int c_DATA_W = ROB_W + 32;
    localparam int c_CNT_W  = $clog2(NUM_REQ + 1);

    logic [c_DATA_W-1:0]    w_head [NUM_REQ];
    logic [NUM_REQ-1:0]     w_empty;
    logic [NUM_REQ-1:0]     w_full;
    logic [NUM_REQ-1:0]     w_push;
    logic [NUM_REQ-1:0]     w_pop;
    logic                   w_advance;
    logic                   w_found;
    logic [CDB_SRC_BIT-1:0] w_win;
    logic [c_CNT_W-1:0]     w_busy_cnt;
    logic                   w_multi;

    logic [CDB_SRC_BIT-1:0] r_rr_ptr;
    logic                   r_cdb_valid;
    logic [ROB_W-1:0]       r_cdb_rob_id;
    logic [31:0]            r_cdb_value;
    logic [CDB_SRC_BIT-1:0] r_cdb_src;
    logic [15:0]            r_stall_count;

    assign w_advance = rdy_in && !clear;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_queue
            // Readiness looks only at fullness, never at a same-cycle pop.
            assign req_ready[i] = w_advance && !w_full[i];
            assign w_push[i]    = req_valid[i] && req_ready[i];
            assign w_pop[i]     = w_advance && w_found && (w_win == CDB_SRC_BIT'(i));

            cdb_queue #(
                .DEPTH_BIT (DEPTH_BIT),
                .DATA_W    (c_DATA_W)
            ) u_queue (
                .clk_in    (clk_in),
                .rst_n_in  (rst_n_in),
                .flush     (clear),
                .push      (w_push[i]),
                .pop       (w_pop[i]),
                .push_data ({req_rob_id[i*ROB_W +: ROB_W], req_value[i*32 +: 32]}),
                .head      (w_head[i]),
                .empty     (w_empty[i]),
                .full      (w_full[i])
            );
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && !w_empty[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = CDB_SRC_BIT'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_busy_cnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_busy_cnt = w_busy_cnt + c_CNT_W'(!w_empty[k]);
        end
    end
    assign w_multi = (w_busy_cnt >= c_CNT_W'(2));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rr_ptr      <= '0;
            r_cdb_valid   <= 1'b0;
            r_cdb_rob_id  <= '0;
            r_cdb_value   <= '0;
            r_cdb_src     <= '0;
            r_stall_count <= '0;
        end else if (clear) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
        end else if (!rdy_in) begin
            r_cdb_valid <= 1'b0;
        end else begin
            if (w_multi && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_found) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_rob_id <= w_head[w_win][32 +: ROB_W];
                r_cdb_value  <= w_head[w_win][31:0];
                r_cdb_src    <= w_win;
                r_rr_ptr     <= cdb_next_src(w_win, NUM_REQ);
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_rob_id  = r_cdb_rob_id;
    assign cdb_value   = r_cdb_value;
    assign cdb_src     = r_cdb_src;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cdb_arbiter                                             |
// | Brief   : Directed self-checking bench for cdb_arbiter.              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int RW = ROB_WIDTH_BIT;

    logic            clk_in;
    logic            rst_n_in;
    logic            rdy_in;
    logic            clear;
    logic [2:0]      req_valid;
    logic [3*RW-1:0] req_rob_id;
    logic [95:0]     req_value;
    logic [2:0]      req_ready;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob_id;
    logic [31:0]     cdb_value;
    logic [1:0]      cdb_src;
    logic [15:0]     stall_count;

    int n_total = 0;
    int n_bad   = 0;

    cdb_arbiter dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_rob_id  (req_rob_id),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cdb_valid   (cdb_valid),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src),
        .stall_count (stall_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic v, input logic [RW-1:0] id,
                             input logic [31:0] val, input logic [1:0] src);
        check({tag, "_valid"}, 64'(cdb_valid), 64'(v));
        check({tag, "_id"},    64'(cdb_rob_id), 64'(id));
        check({tag, "_value"}, 64'(cdb_value), 64'(val));
        check({tag, "_src"},   64'(cdb_src), 64'(src));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] id, input logic [31:0] val);
        req_valid[i]           = 1'b1;
        req_rob_id[i*RW +: RW] = id;
        req_value[i*32 +: 32]  = val;
    endtask

    task automatic clr_req();
        req_valid = '0;
    endtask

    initial begin
        rst_n_in   = 1'b0;
        rdy_in     = 1'b1;
        clear      = 1'b0;
        req_valid  = '0;
        req_rob_id = '0;
        req_value  = '0;

        // Reset state
        #12;
        check("rst_ready", 64'(req_ready), 64'h7);
        check_cdb("rst", 1'b0, '0, 32'h0, 2'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        #1 rst_n_in = 1'b1;
        step();

        // Single push with one-cycle latency
        set_req(0, 5'd3, 32'hDEAD_BEEF);
        step();
        clr_req();
        check("t1_latency", 64'(cdb_valid), 64'd0);
        step();
        check_cdb("t1", 1'b1, 5'd3, 32'hDEAD_BEEF, CDB_SRC_ALU);
        step();
        check("t1_off", 64'(cdb_valid), 64'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Round robin over all three requesters
        set_req(0, 5'd1, 32'h101);
        set_req(1, 5'd2, 32'h102);
        set_req(2, 5'd3, 32'h103);
        step();
        clr_req();
        step();
        check_cdb("t2_g0", 1'b1, 5'd1, 32'h101, CDB_SRC_ALU);
        step();
        check_cdb("t2_g1", 1'b1, 5'd2, 32'h102, CDB_SRC_LSB);
        step();
        check_cdb("t2_g2", 1'b1, 5'd3, 32'h103, CDB_SRC_MUL);
        check("t2_stall", 64'(stall_count), 64'd2);
        step();
        check("t2_idle", 64'(cdb_valid), 64'd0);
        set_req(0, 5'd8, 32'h108);
        set_req(2, 5'd9, 32'h109);
        step();
        clr_req();
        step();
        check_cdb("t2_wrap0", 1'b1, 5'd8, 32'h108, CDB_SRC_ALU);
        check("t2_stall3", 64'(stall_count), 64'd3);
        step();
        check_cdb("t2_wrap2", 1'b1, 5'd9, 32'h109, CDB_SRC_MUL);
        step();

        // Backpressure: LSB queue fills while ALU holds the grant
        set_req(0, 5'd10, 32'h10A);
        set_req(1, 5'd4,  32'h204);
        set_req(2, 5'd11, 32'h10B);
        step();
        clr_req();
        set_req(1, 5'd5, 32'h205);
        step();
        check_cdb("t3_b", 1'b1, 5'd10, 32'h10A, CDB_SRC_ALU);
        check("t3_full_ready", 64'(req_ready), 64'h5);
        set_req(1, 5'd6, 32'h206);
        step();
        clr_req();
        check_cdb("t3_c", 1'b1, 5'd4, 32'h204, CDB_SRC_LSB);
        step();
        check_cdb("t3_d", 1'b1, 5'd11, 32'h10B, CDB_SRC_MUL);
        step();
        check_cdb("t3_e", 1'b1, 5'd5, 32'h205, CDB_SRC_LSB);
        step();
        check("t3_no6", 64'(cdb_valid), 64'd0);
        check("t3_stall", 64'(stall_count), 64'd6);

        // Clear with three queued entries
        set_req(0, 5'd12, 32'h30C);
        set_req(1, 5'd13, 32'h30D);
        set_req(2, 5'd14, 32'h30E);
        step();
        clr_req();
        set_req(0, 5'd16, 32'h310);
        step();
        clr_req();
        check_cdb("t4_q", 1'b1, 5'd14, 32'h30E, CDB_SRC_MUL);
        check("t4_stall_q", 64'(stall_count), 64'd7);
        clear = 1'b1;
        set_req(0, 5'd15, 32'h30F);
        #1;
        check("t4_ready_clr", 64'(req_ready), 64'h0);
        step();
        clear = 1'b0;
        clr_req();
        #1;
        check("t4_valid", 64'(cdb_valid), 64'd0);
        check("t4_ready", 64'(req_ready), 64'h7);
        check("t4_stall", 64'(stall_count), 64'd7);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_quiet", 64'(cdb_valid), 64'd0);
        end

        // rdy_in pause
        set_req(2, 5'd7, 32'h407);
        step();
        clr_req();
        rdy_in = 1'b0;
        #1;
        check("t5_ready", 64'(req_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_paused", 64'(cdb_valid), 64'd0);
        end
        rdy_in = 1'b1;
        step();
        check_cdb("t5_resume", 1'b1, 5'd7, 32'h407, CDB_SRC_MUL);
        check("t5_stall", 64'(stall_count), 64'd7);

        // Asynchronous reset mid-stream
        set_req(0, 5'd20, 32'h514);
        set_req(1, 5'd21, 32'h515);
        step();
        clr_req();
        step();
        check_cdb("t6_pre", 1'b1, 5'd20, 32'h514, CDB_SRC_ALU);
        #2 rst_n_in = 1'b0;
        #1;
        check_cdb("t6_async", 1'b0, '0, 32'h0, 2'd0);
        check("t6_stall", 64'(stall_count), 64'd0);
        #2 rst_n_in = 1'b1;
        step();
        step();
        check("t6_dropped", 64'(cdb_valid), 64'd0);
        check("t6_ready", 64'(req_ready), 64'h7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
